fetch_unit: RTL and testbench

- Parametrised N-wide instruction fetch front end, the successor to the fixed 4-wide, free-running pc+8 fetch in the CPU top.
- Owns the PC and issues WIDTH consecutive halfword-aligned word addresses per group to the multi-port synchronous instruction memory (1-cycle read latency).
- Buffers returned groups in a small queue and hands them to decode stage 1 over a valid/ready handshake.
- Supports backpressure, branch redirect with squash of in-flight and buffered groups, and halt.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default geometry and the fetch-group record
// handed from fetch to decode.
package fetch_pkg;

    localparam int              DEF_WIDTH    = 4;
    localparam int              DEF_ADDR_W   = 16;
    localparam int              DEF_INSTR_W  = 16;
    localparam int              DEF_QDEPTH   = 3;
    localparam logic [15:0]     DEF_RESET_PC = 16'h0000;

    // Group record at the default geometry; decode reuses this layout.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]                     pc;
        logic [DEF_WIDTH-1:0][DEF_INSTR_W-1:0]     instr;
    } fetch_group_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch groups; depth need not be a power of two.
// Head is read straight from the entry array so a pushed group is visible next cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W = DEF_ADDR_W + DEF_WIDTH * DEF_INSTR_W,
    parameter int QDEPTH = DEF_QDEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [DATA_W-1:0]                push_data,
    input  logic                             pop,
    input  logic                             flush,
    output logic [cnt_width(QDEPTH)-1:0]     count,
    output logic [DATA_W-1:0]                head
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = cnt_width(QDEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [DATA_W-1:0] entry_rd [QDEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
        logic [DATA_W-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                entry_reg <= push_data;
            end
        end

        assign entry_rd[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            // The issue credit in the parent must never let a push hit a full queue.
            assert (!(push && (count_reg == FULL_CNT)));
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = entry_rd[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// N-wide instruction fetch front end: owns the PC, issues a group of word
// addresses per cycle to a 1-cycle imem and queues the returned groups for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                WIDTH    = DEF_WIDTH,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                QDEPTH   = DEF_QDEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req,
    output logic [WIDTH*(ADDR_W-1)-1:0] imem_addr,
    input  logic [WIDTH*INSTR_W-1:0]    imem_data,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        halt_i,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [WIDTH*INSTR_W-1:0]    out_instr,
    output logic [31:0]                 fetch_cnt
);

    localparam int WADDR_W = ADDR_W - 1;
    localparam int DATA_W  = WIDTH * INSTR_W;
    localparam int GRP_W   = ADDR_W + DATA_W;
    localparam int CNT_W   = cnt_width(QDEPTH);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] tag_reg;
    logic              inflight_reg;
    logic [31:0]       fetch_cnt_reg;

    logic [CNT_W-1:0]  count;
    logic [GRP_W-1:0]  head;
    logic [CNT_W:0]    used;
    logic              issue;
    logic              push;
    logic              pop;

    // Credit counts queued plus in-flight groups; a same-cycle pop is deliberately
    // not credited so out_ready stays off the imem_req path.
    assign used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue = !halt_i && !redirect_valid && (used < (CNT_W + 1)'(QDEPTH));
    assign push  = inflight_reg && !redirect_valid;
    assign pop   = out_valid && out_ready;

    assign imem_req = issue && rst_n;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot
        assign imem_addr[gi*WADDR_W +: WADDR_W] = pc_reg[ADDR_W-1:1] + WADDR_W'(gi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg        <= RESET_PC;
            tag_reg       <= '0;
            inflight_reg  <= 1'b0;
            fetch_cnt_reg <= '0;
        end else begin
            if (redirect_valid) begin
                pc_reg <= redirect_pc & ~ADDR_W'(1);
            end else if (issue) begin
                pc_reg <= pc_reg + ADDR_W'(2 * WIDTH);
            end
            inflight_reg <= issue;
            if (issue) begin
                tag_reg <= pc_reg;
            end
            if (pop && (fetch_cnt_reg != '1)) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
        end
    end

    fetch_queue #(
        .DATA_W (GRP_W),
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({tag_reg, imem_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign out_valid = (count != '0);
    assign out_pc    = head[GRP_W-1 -: ADDR_W];
    assign out_instr = head[DATA_W-1:0];
    assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked against a
// transaction-level model of the fetch stream (outstanding groups with ready times).
module tb_fetch_unit;

    localparam int W  = 4;
    localparam int AW = 16;
    localparam int IW = 16;
    localparam int QD = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [W*15-1:0]   imem_addr;
    logic [W*IW-1:0]   imem_data;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic              halt_i;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_pc;
    logic [W*IW-1:0]   out_instr;
    logic [31:0]       fetch_cnt;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_i         (halt_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed scramble of the word address.
    function automatic logic [15:0] mem_word(input logic [14:0] w);
        return (16'(w) * 16'h9E37) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            imem_data[i*IW +: IW] <= mem_word(imem_addr[i*15 +: 15]);
        end
    end

    function automatic logic [59:0] group_addr(input logic [15:0] pc);
        logic [59:0] r;
        logic [15:0] b;
        r = '0;
        for (int i = 0; i < W; i++) begin
            b = pc + 16'(2 * i);
            r[i*15 +: 15] = b[15:1];
        end
        return r;
    endfunction

    function automatic logic [63:0] group_instr(input logic [15:0] pc);
        logic [63:0] r;
        logic [15:0] b;
        r = '0;
        for (int i = 0; i < W; i++) begin
            b = pc + 16'(2 * i);
            r[i*IW +: IW] = mem_word(b[15:1]);
        end
        return r;
    endfunction

    typedef struct {
        int          rdy;
        logic [15:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    longint      m_cnt;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc  = 16'h0000;
        m_cnt = 0;
        cyc   = 0;
    endtask

    // One clock: check outputs against the model, advance the model, step to next negedge.
    task automatic cycle();
        bit   exp_req;
        bit   exp_valid;
        ent_t e;
        #1;
        exp_req   = !halt_i && !redirect_valid && (mq.size() < QD);
        exp_valid = (mq.size() > 0) && (mq[0].rdy <= cyc);
        chk("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(group_addr(m_pc)));
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
            chk("out_instr", out_instr, group_instr(mq[0].pc));
        end
        chk("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
        if (exp_valid && out_ready) begin
            $display("[%0d] deliver pc=%h instr=%h", cyc, out_pc, out_instr);
            e = mq.pop_front();
            m_cnt++;
        end
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & 16'hFFFE;
        end else if (exp_req) begin
            e.rdy = cyc + 2;
            e.pc  = m_pc;
            mq.push_back(e);
            m_pc = m_pc + 16'd8;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_i         = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        #1;
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_out_instr", out_instr, 64'd0);
        chk("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [59:0] a;

        // Free-running fetch from reset.
        do_reset();
        #1;
        a = {15'h0003, 15'h0002, 15'h0001, 15'h0000};
        chk("t1_addr0", 64'(imem_addr), 64'(a));
        run(10);

        // Backpressure from cycle 2, then release.
        do_reset();
        run(2);
        out_ready = 1'b0;
        run(5);
        #1;
        chk("t2_req_blocked", 64'(imem_req), 64'd0);
        chk("t2_hold_pc", 64'(out_pc), 64'h0000);
        out_ready = 1'b1;
        run(10);

        // Redirect at cycle 5.
        do_reset();
        run(5);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        cycle();
        redirect_valid = 1'b0;
        #1;
        chk("t3_valid_gap", 64'(out_valid), 64'd0);
        a = {15'h0023, 15'h0022, 15'h0021, 15'h0020};
        chk("t3_new_addr", 64'(imem_addr), 64'(a));
        run(2);
        #1;
        chk("t3_new_pc", 64'(out_pc), 64'h0040);
        run(6);

        // Halt for cycles 4..9.
        do_reset();
        run(4);
        halt_i = 1'b1;
        run(2);
        #1;
        chk("t4_drained", 64'(out_valid), 64'd0);
        run(4);
        halt_i = 1'b0;
        run(2);
        #1;
        chk("t4_resume_valid", 64'(out_valid), 64'd1);
        chk("t4_resume_pc", 64'(out_pc), 64'h0020);
        run(4);

        // Address wrap through the top of the address space.
        do_reset();
        run(2);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFF4;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        #1;
        a = {15'h0001, 15'h0000, 15'h7FFF, 15'h7FFE};
        chk("t5_wrap_addr", 64'(imem_addr), 64'(a));
        run(8);

        // Async reset mid-stream with two groups queued.
        do_reset();
        out_ready = 1'b0;
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_pc", 64'(out_pc), 64'd0);
        chk("t6_async_instr", out_instr, 64'd0);
        chk("t6_async_req", 64'(imem_req), 64'd0);
        do_reset();
        run(8);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            halt_i         = ($urandom_range(0, 9) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = 16'($urandom);
            cycle();
        end
        redirect_valid = 1'b0;
        halt_i         = 1'b0;
        out_ready      = 1'b1;
        run(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
